// File: rtl/axil_pkg.sv
// Link timing constants shared with the AXI-Lite SPI master side.
// The ratio CLOCK/SPI_FREQ must stay >= 10 so the slave has time to drive MISO.
package axil_pkg;

   localparam int CLOCK    = 100_000_000;
   localparam int SPI_FREQ = 10_000_000;

endpackage

// File: rtl/spi_pkg.sv
// Frame layout and FSM encoding shared by the SPI slave register bank and its bench.
package spi_pkg;

   localparam int RD_FLAG_BIT = 7;
   localparam int FRAME_BITS  = 16;
   localparam int ADDR_BITS   = FRAME_BITS / 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA_WR,
      ST_DATA_RD,
      ST_DONE
   } spi_state_e;

   // Register indices arrive as 7 bits but the bank may be smaller.
   function automatic logic idx_in_range(input logic [6:0] idx, input int reg_num);
      return int'(idx) < reg_num;
   endfunction

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between an SPI master and the slave register bank.
interface spi_slave_regfile_if;

   logic spi_cs;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_miso;

   modport master (
      output spi_cs,
      output spi_sclk,
      output spi_mosi,
      input  spi_miso
   );

   modport slave (
      input  spi_cs,
      input  spi_sclk,
      input  spi_mosi,
      output spi_miso
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an idle-high SPI pin, with one-cycle rise/fall pulses
// derived from the synchronized level and a registered copy of it.
module spi_sync_edge (
   input  logic aclk,
   input  logic aresetn,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[0], din};
      prev_d = sync_q[1];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[1] & ~prev_q;
   assign fall = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave register bank: decodes 16-bit address+data frames on oversampled pins
// and reads/writes an 8-bit register array that local logic can also update.
module spi_slave_regfile
   import spi_pkg::*;
#(
   parameter int REG_NUM = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   spi_slave_regfile_if.slave         spi,
   output logic [REG_NUM*8-1:0]       regs,
   input  logic                       upd_en,
   input  logic [$clog2(REG_NUM)-1:0] upd_addr,
   input  logic [7:0]                 upd_data,
   output logic                       wr_valid,
   output logic [6:0]                 wr_addr,
   output logic                       frame_err
);

   localparam int IDX_W = $clog2(REG_NUM);

   logic cs_rise, cs_fall;
   logic sclk_rise, sclk_fall;

   spi_sync_edge u_cs_sync (
      .aclk    (aclk),
      .aresetn (aresetn),
      .din     (spi.spi_cs),
      .rise    (cs_rise),
      .fall    (cs_fall)
   );

   spi_sync_edge u_sclk_sync (
      .aclk    (aclk),
      .aresetn (aresetn),
      .din     (spi.spi_sclk),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   logic [1:0]  mosi_q, mosi_d;
   spi_state_e  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic [7:0]  tx_q, tx_d;
   logic        miso_q, miso_d;
   logic        wr_valid_q, wr_valid_d;
   logic [6:0]  wr_addr_q, wr_addr_d;
   logic        frame_err_q, frame_err_d;
   logic [7:0]  regs_q [REG_NUM];
   logic [7:0]  regs_d [REG_NUM];

   // NOTE: every variable gets its default before the case statement, so no
   // path through this block can leave a latch behind.
   always_comb begin
      mosi_d      = {mosi_q[0], spi.spi_mosi};
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      tx_d        = tx_q;
      miso_d      = miso_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      frame_err_d = 1'b0;
      regs_d      = regs_q;

      // Local write first; an SPI commit in the same cycle overrides it below.
      if (upd_en && idx_in_range(7'(upd_addr), REG_NUM)) begin
         regs_d[upd_addr] = upd_data;
      end

      unique case (state_q)
         ST_IDLE: begin
            miso_d = 1'b1;
            if (cs_fall) begin
               state_d   = ST_ADDR;
               bit_cnt_d = '0;
            end
         end

         ST_ADDR: begin
            if (cs_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
               miso_d      = 1'b1;
            end else if (sclk_rise) begin
               addr_d    = {addr_q[6:0], mosi_q[1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (addr_d[RD_FLAG_BIT]) begin
                     state_d = ST_DATA_RD;
                     tx_d    = idx_in_range(addr_d[6:0], REG_NUM) ?
                               regs_q[addr_d[IDX_W-1:0]] : 8'h00;
                  end else begin
                     state_d = ST_DATA_WR;
                  end
               end
            end
         end

         ST_DATA_WR: begin
            if (cs_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
               miso_d      = 1'b1;
            end else if (sclk_rise) begin
               data_d    = {data_q[6:0], mosi_q[1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d    = ST_DONE;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = addr_q[6:0];
                  if (idx_in_range(addr_q[6:0], REG_NUM)) begin
                     regs_d[addr_q[IDX_W-1:0]] = data_d;
                  end
               end
            end
         end

         ST_DATA_RD: begin
            if (cs_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
               miso_d      = 1'b1;
            end else begin
               // Drive on falling edges so the master sees a stable bit at its rising edge.
               if (sclk_fall) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_DONE;
                     miso_d  = 1'b1;
                  end
               end
            end
         end

         ST_DONE: begin
            miso_d = 1'b1;
            if (cs_rise) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            miso_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         mosi_q      <= 2'b11;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         tx_q        <= '0;
         miso_q      <= 1'b1;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         frame_err_q <= 1'b0;
         // NOTE: the bank is a set of visible registers with defined reset values,
         // so it is reset in full here rather than treated as an uninitialised RAM.
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         mosi_q      <= mosi_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         frame_err_q <= frame_err_d;
         regs_q      <= regs_d;
      end
   end

   for (genvar i = 0; i < REG_NUM; i++) begin : g_regs_flat
      assign regs[8*i +: 8] = regs_q[i];
   end

   assign spi.spi_miso = miso_q;
   assign wr_valid     = wr_valid_q;
   assign wr_addr      = wr_addr_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomized scoreboard bench for spi_slave_regfile: a bench-side SPI master drives
// frames, a register-array model predicts results, a monitor compares DUT outputs.
module tb_spi_slave_regfile;
   import spi_pkg::*;
   import axil_pkg::*;

   localparam int REG_NUM = 16;
   localparam int W       = REG_NUM * 8;
   localparam int HALF    = CLOCK / SPI_FREQ / 2;
   localparam int CLK_NS  = 10;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          upd_en = 1'b0;
   logic [3:0]    upd_addr = '0;
   logic [7:0]    upd_data = '0;
   logic [W-1:0]  regs;
   logic          wr_valid;
   logic [6:0]    wr_addr;
   logic          frame_err;

   spi_slave_regfile_if spi_if ();

   spi_slave_regfile #(.REG_NUM(REG_NUM)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .spi       (spi_if),
      .regs      (regs),
      .upd_en    (upd_en),
      .upd_addr  (upd_addr),
      .upd_data  (upd_data),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .frame_err (frame_err)
   );

   always #(CLK_NS / 2) aclk = ~aclk;

   typedef struct {
      logic [6:0]   addr;
      logic [W-1:0] regs;
   } wr_exp_t;

   logic [7:0]   model [REG_NUM];
   wr_exp_t      exp_wr_q [$];
   logic [W-1:0] exp_err_q [$];
   logic [7:0]   exp_rd_q [$];
   logic [7:0]   got_rd_q [$];
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [W-1:0] flat_model();
      logic [W-1:0] f;
      for (int i = 0; i < REG_NUM; i++) f[8*i +: 8] = model[i];
      return f;
   endfunction

   function automatic logic [7:0] model_read(input logic [6:0] idx);
      return (int'(idx) < REG_NUM) ? model[idx[3:0]] : 8'h00;
   endfunction

   // Monitor: compares whatever the DUT presents against the oldest expectation.
   wr_exp_t    mon_wr;
   logic [W-1:0] mon_err;
   logic [7:0] mon_got;
   always @(negedge aclk) begin
      if (aresetn) begin
         if (wr_valid) begin
            check("wr_expected", 128'(exp_wr_q.size() != 0), 128'(1));
            if (exp_wr_q.size() != 0) begin
               mon_wr = exp_wr_q.pop_front();
               check("wr_addr", 128'(wr_addr), 128'(mon_wr.addr));
               check("wr_regs", 128'(regs), 128'(mon_wr.regs));
            end
         end
         if (frame_err) begin
            check("err_expected", 128'(exp_err_q.size() != 0), 128'(1));
            if (exp_err_q.size() != 0) begin
               mon_err = exp_err_q.pop_front();
               check("err_regs", 128'(regs), 128'(mon_err));
            end
         end
         while (got_rd_q.size() != 0) begin
            mon_got = got_rd_q.pop_front();
            check("rd_expected", 128'(exp_rd_q.size() != 0), 128'(1));
            if (exp_rd_q.size() != 0) check("rd_data", 128'(mon_got), 128'(exp_rd_q.pop_front()));
         end
      end
   end

   // Bench-side SPI master, mode 3: MOSI changes on falling SCLK, both sides sample on rising.
   task automatic spi_frame(input logic [7:0] addr, input logic [7:0] data, input int n_edges,
                            input bit collide, input int rst_edge,
                            output logic [7:0] rd, output bit miso_idle);
      logic [15:0] frame;
      frame = {addr, data};
      rd = '0;
      miso_idle = 1'b1;
      @(negedge aclk);
      spi_if.spi_cs = 1'b0;
      repeat (HALF) @(negedge aclk);
      for (int i = 0; i < n_edges; i++) begin
         if (i == rst_edge) begin
            aresetn = 1'b0;
            spi_if.spi_cs = 1'b1;
            spi_if.spi_sclk = 1'b1;
            spi_if.spi_mosi = 1'b1;
            return;
         end
         spi_if.spi_sclk = 1'b0;
         spi_if.spi_mosi = frame[15-i];
         repeat (HALF) @(negedge aclk);
         spi_if.spi_sclk = 1'b1;
         if (i >= 8) rd = {rd[6:0], spi_if.spi_miso};
         if (i < 8 || !addr[7]) miso_idle = miso_idle & (spi_if.spi_miso == 1'b1);
         if (collide && i == 15) begin
            // Commit lands on the third aclk edge after the pin change.
            repeat (2) @(negedge aclk);
            upd_en = 1'b1;
            @(negedge aclk);
            upd_en = 1'b0;
            repeat (HALF - 3) @(negedge aclk);
         end else begin
            repeat (HALF) @(negedge aclk);
         end
      end
      repeat (HALF) @(negedge aclk);
      spi_if.spi_cs = 1'b1;
      repeat (2 * HALF) @(negedge aclk);
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input bit collide);
      wr_exp_t e;
      logic [7:0] rd;
      bit idle;
      if (int'(addr[6:0]) < REG_NUM) model[addr[3:0]] = data;
      e.addr = addr[6:0];
      e.regs = flat_model();
      exp_wr_q.push_back(e);
      spi_frame({1'b0, addr[6:0]}, data, FRAME_BITS, collide, -1, rd, idle);
      check("miso_idle_wr", 128'(idle), 128'(1));
   endtask

   task automatic do_read(input logic [6:0] idx);
      logic [7:0] rd;
      bit idle;
      exp_rd_q.push_back(model_read(idx));
      spi_frame({1'b1, idx}, 8'h00, FRAME_BITS, 1'b0, -1, rd, idle);
      got_rd_q.push_back(rd);
      check("miso_idle_rd_addr", 128'(idle), 128'(1));
      check("regs_after_rd", 128'(regs), 128'(flat_model()));
   endtask

   task automatic do_local(input logic [3:0] idx, input logic [7:0] data);
      @(negedge aclk);
      upd_en = 1'b1;
      upd_addr = idx;
      upd_data = data;
      @(negedge aclk);
      upd_en = 1'b0;
      model[idx] = data;
      check("local_upd", 128'(regs), 128'(flat_model()));
   endtask

   initial begin
      #(CLK_NS * 90000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rd;
      bit idle;
      logic [6:0] ridx;
      spi_if.spi_cs = 1'b1;
      spi_if.spi_sclk = 1'b1;
      spi_if.spi_mosi = 1'b1;
      for (int i = 0; i < REG_NUM; i++) model[i] = 8'h00;

      repeat (3) @(negedge aclk);
      check("rst_miso", 128'(spi_if.spi_miso), 128'(1));
      check("rst_regs", 128'(regs), 128'(0));
      check("rst_wr_valid", 128'(wr_valid), 128'(0));
      check("rst_wr_addr", 128'(wr_addr), 128'(0));
      check("rst_frame_err", 128'(frame_err), 128'(0));
      aresetn = 1'b1;
      repeat (5) @(negedge aclk);

      // Directed cases.
      do_write(8'h05, 8'hA5, 1'b0);
      check("write_05", 128'(regs[5*8 +: 8]), 128'(8'hA5));
      do_local(4'd3, 8'h3C);
      do_read(7'h03);
      do_read(7'h7F);
      do_write(8'h20, 8'h77, 1'b0);
      upd_addr = 4'd7;
      upd_data = 8'h11;
      do_write(8'h07, 8'h22, 1'b1);
      repeat (4) @(negedge aclk);
      check("collide_spi_wins", 128'(regs[7*8 +: 8]), 128'(8'h22));

      // Early CS release inside the data phase, then a clean frame to the same index.
      exp_err_q.push_back(flat_model());
      spi_frame(8'h02, 8'hFF, 10, 1'b0, -1, rd, idle);
      check("abort_regs2", 128'(regs[2*8 +: 8]), 128'(model[2]));
      do_write(8'h02, 8'h5A, 1'b0);
      check("write_02", 128'(regs[2*8 +: 8]), 128'(8'h5A));

      // Randomized mix of SPI writes, reads, local updates and aborts.
      for (int n = 0; n < 40; n++) begin
         ridx = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0: do_write({1'b0, ridx}, 8'($urandom), 1'b0);
            1: do_read(ridx);
            2: do_local(4'($urandom_range(0, 15)), 8'($urandom));
            default: begin
               exp_err_q.push_back(flat_model());
               spi_frame({1'b0, ridx}, 8'($urandom), $urandom_range(1, 15), 1'b0, -1, rd, idle);
            end
         endcase
      end
      check("regs_vs_model", 128'(regs), 128'(flat_model()));

      // Reset while the slave is shifting out read data bit 4.
      do_local(4'd0, 8'hC3);
      spi_frame(8'h80, 8'h00, FRAME_BITS, 1'b0, 12, rd, idle);
      #1;
      check("midrst_miso", 128'(spi_if.spi_miso), 128'(1));
      check("midrst_regs", 128'(regs), 128'(0));
      check("midrst_wr_valid", 128'(wr_valid), 128'(0));
      for (int i = 0; i < REG_NUM; i++) model[i] = 8'h00;
      repeat (5) @(negedge aclk);
      aresetn = 1'b1;
      repeat (5) @(negedge aclk);
      do_read(7'h00);

      repeat (20) @(negedge aclk);
      check("wr_queue_drained", 128'(exp_wr_q.size()), 128'(0));
      check("err_queue_drained", 128'(exp_err_q.size()), 128'(0));
      check("rd_queue_drained", 128'(exp_rd_q.size()), 128'(0));
      check("final_regs", 128'(regs), 128'(flat_model()));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
